inst_queue: RTL and testbench

Instruction prefetch queue sitting directly downstream of the instruction-fetch control and ROM pair. It captures each fetched `{pc, inst}` pair from the fetch stage, buffers up to DEPTH entries, and presents them in order to the decode stage over a valid/ready handshake. A flush input, driven by branch/jump redirection, discards all buffered entries so that wrong-path instructions never reach decode.

---
 rtl/inst_queue.sv | 77 +++++++
 tb/tb_inst_queue.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// Instruction prefetch queue between fetch and decode: a DEPTH-entry circular
// buffer of {pc, inst} with valid/ready handshakes and a flush that drops all entries.
module inst_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              push_valid_i,
  input  logic [ADDR_W-1:0] push_pc_i,
  input  logic [DATA_W-1:0] push_inst_i,
  output logic              push_ready_o,
  output logic              pop_valid_o,
  output logic [ADDR_W-1:0] pop_pc_o,
  output logic [DATA_W-1:0] pop_inst_o,
  input  logic              pop_ready_i,
  output logic [CNT_W-1:0]  count_o
);

  logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
  logic [DATA_W-1:0] r_inst_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_push;
  logic w_pop;

  // Ready depends only on occupancy, so a full queue refuses a push even while popping.
  assign push_ready_o = (r_count < CNT_W'(DEPTH));
  assign pop_valid_o  = (r_count != '0);
  assign count_o      = r_count;

  // Flush wins over both handshakes: the offered entry is dropped and the head is not consumed.
  assign w_push = push_valid_i && push_ready_o && !flush_i;
  assign w_pop  = pop_valid_o  && pop_ready_i  && !flush_i;

  assign pop_pc_o   = pop_valid_o ? r_pc_mem[r_rd_ptr]   : '0;
  assign pop_inst_o = pop_valid_o ? r_inst_mem[r_rd_ptr] : '0;

  // NOTE: storage has no reset; stale entries are never visible because the
  // outputs are gated by count, and leaving it unreset lets it map to plain RAM/regs.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= push_pc_i;
      r_inst_mem[r_wr_ptr] <= push_inst_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers are PTR_W bits wide, so DEPTH being a power of two makes them wrap for free.
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed, table-driven bench for inst_queue: vectors are applied one per clock
// and the outputs compared at the following falling edge.
module tb_inst_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush_i;
  logic              push_valid_i;
  logic [ADDR_W-1:0] push_pc_i;
  logic [DATA_W-1:0] push_inst_i;
  logic              push_ready_o;
  logic              pop_valid_o;
  logic [ADDR_W-1:0] pop_pc_o;
  logic [DATA_W-1:0] pop_inst_o;
  logic              pop_ready_i;
  logic [CNT_W-1:0]  count_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic              flush;
    logic              push_valid;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
    logic              pop_ready;
    logic [CNT_W-1:0]  e_count;
    logic              e_pop_valid;
    logic [ADDR_W-1:0] e_pc;
    logic [DATA_W-1:0] e_inst;
    logic              e_push_ready;
  } vec_t;

  vec_t vecs[$];

  inst_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .push_valid_i (push_valid_i),
    .push_pc_i    (push_pc_i),
    .push_inst_i  (push_inst_i),
    .push_ready_o (push_ready_o),
    .pop_valid_o  (pop_valid_o),
    .pop_pc_o     (pop_pc_o),
    .pop_inst_o   (pop_inst_o),
    .pop_ready_i  (pop_ready_i),
    .count_o      (count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input int ec, input logic ev,
                               input logic [31:0] epc, input logic [31:0] einst,
                               input logic er);
    check({tag, " count"},      32'(count_o),      32'(ec));
    check({tag, " pop_valid"},  32'(pop_valid_o),  32'(ev));
    check({tag, " pop_pc"},     pop_pc_o,          epc);
    check({tag, " pop_inst"},   pop_inst_o,        einst);
    check({tag, " push_ready"}, 32'(push_ready_o), 32'(er));
  endtask

  task automatic add(input logic fl, input logic pv, input logic [31:0] pc,
                     input logic [31:0] inst, input logic pr, input int ec,
                     input logic ev, input logic [31:0] epc, input logic [31:0] einst,
                     input logic er);
    vec_t v;
    v.flush = fl; v.push_valid = pv; v.pc = pc; v.inst = inst; v.pop_ready = pr;
    v.e_count = CNT_W'(ec); v.e_pop_valid = ev; v.e_pc = epc; v.e_inst = einst;
    v.e_push_ready = er;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic fl, input logic pv, input logic [31:0] pc,
                       input logic [31:0] inst, input logic pr);
    flush_i = fl; push_valid_i = pv; push_pc_i = pc; push_inst_i = inst; pop_ready_i = pr;
  endtask

  initial begin
    //   flush push pc      inst     pop | count valid pc      inst     ready
    // Fill to full with decode stalled; the head stays at the first entry.
    add(0, 1, 32'h00, 32'h11, 0,   1, 1, 32'h00, 32'h11, 1);
    add(0, 1, 32'h04, 32'h22, 0,   2, 1, 32'h00, 32'h11, 1);
    add(0, 1, 32'h08, 32'h33, 0,   3, 1, 32'h00, 32'h11, 1);
    add(0, 1, 32'h0C, 32'h44, 0,   4, 1, 32'h00, 32'h11, 0);
    // Full: push refused even with a simultaneous pop; 0x10 must never appear.
    add(0, 1, 32'h10, 32'h55, 1,   3, 1, 32'h04, 32'h22, 1);
    add(0, 0, 32'h00, 32'h00, 1,   2, 1, 32'h08, 32'h33, 1);
    add(0, 0, 32'h00, 32'h00, 1,   1, 1, 32'h0C, 32'h44, 1);
    add(0, 0, 32'h00, 32'h00, 1,   0, 0, 32'h00, 32'h00, 1);
    // Popping an empty queue has no effect.
    for (int i = 0; i < 3; i++)
      add(0, 0, 32'h00, 32'h00, 1, 0, 0, 32'h00, 32'h00, 1);
    add(0, 1, 32'h20, 32'h99, 0,   1, 1, 32'h20, 32'h99, 1);
    add(0, 0, 32'h00, 32'h00, 1,   0, 0, 32'h00, 32'h00, 1);
    // Flush beats push and pop in the same cycle.
    add(0, 1, 32'h00, 32'hA0, 0,   1, 1, 32'h00, 32'hA0, 1);
    add(0, 1, 32'h04, 32'hA1, 0,   2, 1, 32'h00, 32'hA0, 1);
    add(1, 1, 32'h08, 32'hA2, 1,   0, 0, 32'h00, 32'h00, 1);
    add(0, 1, 32'h40, 32'hB0, 0,   1, 1, 32'h40, 32'hB0, 1);
    add(0, 0, 32'h00, 32'h00, 1,   0, 0, 32'h00, 32'h00, 1);
    // Streaming push+pop every cycle; 16 entries wrap the pointers four times.
    for (int i = 0; i < 16; i++)
      add(0, 1, 32'(i * 4), 32'hC000_0000 | 32'(i), 1,
          1, 1, 32'(i * 4), 32'hC000_0000 | 32'(i), 1);
    add(0, 0, 32'h00, 32'h00, 1,   0, 0, 32'h00, 32'h00, 1);

    drive(0, 0, '0, '0, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs("in_reset", 0, 0, 32'h0, 32'h0, 1);
    rst = 1'b1;
    check_outputs("after_release", 0, 0, 32'h0, 32'h0, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].flush, vecs[i].push_valid, vecs[i].pc, vecs[i].inst, vecs[i].pop_ready);
      @(posedge clk);
      @(negedge clk);
      check_outputs($sformatf("v%0d", i), int'(vecs[i].e_count), vecs[i].e_pop_valid,
                    vecs[i].e_pc, vecs[i].e_inst, vecs[i].e_push_ready);
    end

    // Asynchronous reset mid-stream with three entries held.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 32'h100 + 32'(i * 4), 32'hD0 + 32'(i), 0);
      @(posedge clk);
      @(negedge clk);
    end
    check_outputs("pre_async", 3, 1, 32'h100, 32'hD0, 1);
    drive(0, 1, 32'h200, 32'hEE, 1);
    #2 rst = 1'b0;
    #1 check_outputs("async_rst", 0, 0, 32'h0, 32'h0, 1);
    @(posedge clk);
    @(negedge clk);
    check_outputs("held_rst", 0, 0, 32'h0, 32'h0, 1);
    drive(0, 0, '0, '0, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_outputs("post_rst_idle", 0, 0, 32'h0, 32'h0, 1);
    // First edge after release accepts a push.
    drive(0, 1, 32'h70, 32'h77, 0);
    @(posedge clk);
    @(negedge clk);
    check_outputs("post_rst_push", 1, 1, 32'h70, 32'h77, 1);
    drive(0, 0, '0, '0, 1);
    @(posedge clk);
    @(negedge clk);
    check_outputs("post_rst_pop", 0, 0, 32'h0, 32'h0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
